// File: rtl/fp_round_pack_if.sv
// Result bus between the FP arithmetic units and fp_round_pack, and from fp_round_pack to writeback.
// The slave modport is the round/pack block; the master modport is its environment.
interface fp_round_pack_if #(
    parameter int EXP  = 8,
    parameter int FRAC = 23
);
    logic                 valid_in;
    logic                 ready_out;
    logic                 sign_in;
    logic [EXP-1:0]       exp_in;
    logic [FRAC+3:0]      mant_in;
    logic [4:0]           flags_in;
    logic                 mode_fp_in;
    logic                 round_mode;
    logic                 valid_out;
    logic                 ready_in;
    logic [EXP+FRAC:0]    result;
    logic [4:0]           flags_out;
    logic                 mode_fp_out;

    modport slave (
        input  valid_in, sign_in, exp_in, mant_in, flags_in, mode_fp_in, round_mode, ready_in,
        output ready_out, valid_out, result, flags_out, mode_fp_out
    );

    modport master (
        output valid_in, sign_in, exp_in, mant_in, flags_in, mode_fp_in, round_mode, ready_in,
        input  ready_out, valid_out, result, flags_out, mode_fp_out
    );
endinterface

// File: rtl/fp_round_pack.sv
// Rounds (RNE/RTZ) an unpacked FP result and packs it to binary32 through a 2-stage elastic pipeline.
// Optional macro FP_PACK_SUBNORM_EN: round subnormal inputs instead of flushing them to zero.
module fp_round_pack #(
    parameter int EXP  = 8,
    parameter int FRAC = 23
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fp_round_pack_if.slave              bus
);
    localparam int W  = EXP + FRAC + 1;
    localparam int MW = FRAC + 4;
    localparam logic [EXP-1:0] EXP_ONES = {EXP{1'b1}};
    // Flag bit positions match the producers' F_* definitions.
    localparam int F_OVERFLOW  = 2;
    localparam int F_UNDERFLOW = 1;
    localparam int F_INEXACT   = 0;

    function automatic logic [W+4:0] round_pack(input logic s, input logic [EXP-1:0] e,
                                                input logic [MW-1:0] m, input logic rm);
        logic [FRAC+1:0] sig_s;
        logic            inc_s;
        logic            inexact_s;
        logic [EXP:0]    exp_s;
        logic [W-1:0]    res_s;
        logic [4:0]      fl_s;
        inexact_s = |m[2:0];
        inc_s     = (rm == 1'b0) ? (m[2] & (m[1] | m[0] | m[3])) : 1'b0;
        sig_s     = {1'b0, m[MW-1:3]} + {{(FRAC+1){1'b0}}, inc_s};
        exp_s     = {1'b0, e} + {{EXP{1'b0}}, sig_s[FRAC+1]};
        res_s     = {W{1'b0}};
        fl_s      = 5'b00000;
        if (e == EXP_ONES) begin
            res_s = {s, EXP_ONES, m[MW-2:3]};
        end else if (m == {MW{1'b0}}) begin
            res_s = {s, {(W-1){1'b0}}};
        end else if (e == {EXP{1'b0}}) begin
`ifdef FP_PACK_SUBNORM_EN
            // Integer bit is 0 here; a carry into it lands on the minimum normal exponent.
            res_s                 = {s, {(EXP-1){1'b0}}, sig_s[FRAC], FRAC'(sig_s)};
            fl_s[F_INEXACT]       = inexact_s;
            fl_s[F_UNDERFLOW]     = inexact_s & ~sig_s[FRAC];
`else
            res_s                 = {s, {(W-1){1'b0}}};
            fl_s[F_INEXACT]       = 1'b1;
            fl_s[F_UNDERFLOW]     = 1'b1;
`endif
        end else if (exp_s >= {1'b0, EXP_ONES}) begin
            if (rm == 1'b0) begin
                res_s = {s, EXP_ONES, {FRAC{1'b0}}};
            end else begin
                res_s = {s, EXP_ONES - {{(EXP-1){1'b0}}, 1'b1}, {FRAC{1'b1}}};
            end
            fl_s[F_OVERFLOW] = 1'b1;
            fl_s[F_INEXACT]  = 1'b1;
        end else begin
            // On a carry the truncated significand is already all-zero.
            res_s           = {s, exp_s[EXP-1:0], FRAC'(sig_s)};
            fl_s[F_INEXACT] = inexact_s;
        end
        return {res_s, fl_s};
    endfunction

    logic           s1_valid_r;
    logic           s1_sign_r;
    logic [EXP-1:0] s1_exp_r;
    logic [MW-1:0]  s1_mant_r;
    logic [4:0]     s1_flags_r;
    logic           s1_mode_r;
    logic           s1_rm_r;
    logic           s2_valid_r;
    logic [W-1:0]   s2_result_r;
    logic [4:0]     s2_flags_r;
    logic           s2_mode_r;
    logic [W+4:0]   packed_s;
    logic           s1_load_s;
    logic           s2_load_s;

    assign bus.ready_out   = ~s1_valid_r | ~s2_valid_r | bus.ready_in;
    assign s1_load_s       = bus.valid_in & bus.ready_out;
    assign s2_load_s       = s1_valid_r & (~s2_valid_r | bus.ready_in);
    assign bus.valid_out   = s2_valid_r;
    assign bus.result      = s2_result_r;
    assign bus.flags_out   = s2_flags_r;
    assign bus.mode_fp_out = s2_mode_r;

    // Round and pack the captured beat
    always_comb begin
        packed_s = round_pack(s1_sign_r, s1_exp_r, s1_mant_r, s1_rm_r);
    end

    // Capture stage and output stage registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_sign_r   <= 1'b0;
            s1_exp_r    <= {EXP{1'b0}};
            s1_mant_r   <= {MW{1'b0}};
            s1_flags_r  <= 5'b00000;
            s1_mode_r   <= 1'b0;
            s1_rm_r     <= 1'b0;
            s2_valid_r  <= 1'b0;
            s2_result_r <= {W{1'b0}};
            s2_flags_r  <= 5'b00000;
            s2_mode_r   <= 1'b0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= 1'b1;
                s1_sign_r  <= bus.sign_in;
                s1_exp_r   <= bus.exp_in;
                s1_mant_r  <= bus.mant_in;
                s1_flags_r <= bus.flags_in;
                s1_mode_r  <= bus.mode_fp_in;
                s1_rm_r    <= bus.round_mode;
            end else if (s2_load_s) begin
                s1_valid_r <= 1'b0;
            end
            if (s2_load_s) begin
                s2_valid_r  <= 1'b1;
                s2_result_r <= packed_s[W+4:5];
                s2_flags_r  <= s1_flags_r | packed_s[4:0];
                s2_mode_r   <= s1_mode_r;
            end else if (bus.ready_in) begin
                s2_valid_r  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp_round_pack.sv
// Directed-vector bench for fp_round_pack: rounding, overflow, specials, backpressure and reset.
module tb_fp_round_pack;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    localparam logic [4:0] NV = 5'b10000;
    localparam logic [4:0] DZ = 5'b01000;
    localparam logic [4:0] OF = 5'b00100;
    localparam logic [4:0] UF = 5'b00010;
    localparam logic [4:0] NX = 5'b00001;

    always #5 clk = ~clk;

    fp_round_pack_if bus ();

    fp_round_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic drive(input logic s, input logic [7:0] e, input logic [26:0] m,
                         input logic [4:0] fl, input logic rm, input logic md);
        bus.valid_in   = 1'b1;
        bus.sign_in    = s;
        bus.exp_in     = e;
        bus.mant_in    = m;
        bus.flags_in   = fl;
        bus.round_mode = rm;
        bus.mode_fp_in = md;
    endtask

    // One beat into an empty pipeline with ready_in=1; reports output and latency in cycles.
    task automatic run_one(input logic s, input logic [7:0] e, input logic [26:0] m,
                           input logic [4:0] fl, input logic rm, input logic md,
                           output logic [31:0] res, output logic [4:0] fo,
                           output logic mo, output int lat);
        @(negedge clk);
        bus.ready_in = 1'b1;
        drive(s, e, m, fl, rm, md);
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        lat = 99;
        res = 32'h0;
        fo  = 5'b0;
        mo  = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) begin
                lat = i;
                res = bus.result;
                fo  = bus.flags_out;
                mo  = bus.mode_fp_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.valid_in = 1'b0; bus.sign_in = 1'b0; bus.exp_in = 8'h00; bus.mant_in = 27'h0;
        bus.flags_in = 5'b0; bus.mode_fp_in = 1'b0; bus.round_mode = 1'b0; bus.ready_in = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (bus.valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid_out); else n_pass++;
        n_total++; if (bus.result !== 32'h0) $display("FAIL reset_result got %h want 00000000", bus.result); else n_pass++;
        n_total++; if (bus.flags_out !== 5'b0) $display("FAIL reset_flags got %b want 00000", bus.flags_out); else n_pass++;
        n_total++; if (bus.mode_fp_out !== 1'b0) $display("FAIL reset_mode got %b want 0", bus.mode_fp_out); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (bus.ready_out !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.ready_out); else n_pass++;
    endtask

    task automatic test_rounding();
        logic [31:0] r; logic [4:0] f; logic m; int lat;
        run_one(1'b0, 8'h7F, 27'h4000000, 5'b0, 1'b0, 1'b1, r, f, m, lat);
        n_total++; if (r !== 32'h3F800000) $display("FAIL one_result got %h want 3f800000", r); else n_pass++;
        n_total++; if (f !== 5'b0) $display("FAIL one_flags got %b want 00000", f); else n_pass++;
        n_total++; if (m !== 1'b1) $display("FAIL one_mode got %b want 1", m); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL one_latency got %0d want 2", lat); else n_pass++;
        run_one(1'b0, 8'h7F, 27'h4000004, DZ, 1'b0, 1'b0, r, f, m, lat);
        n_total++; if (r !== 32'h3F800000) $display("FAIL tie_even_result got %h want 3f800000", r); else n_pass++;
        n_total++; if (f !== (DZ | NX)) $display("FAIL tie_even_flags got %b want 01001", f); else n_pass++;
        run_one(1'b0, 8'h7F, 27'h400000C, 5'b0, 1'b0, 1'b0, r, f, m, lat);
        n_total++; if (r !== 32'h3F800002) $display("FAIL tie_odd_rne got %h want 3f800002", r); else n_pass++;
        n_total++; if (f !== NX) $display("FAIL tie_odd_rne_flags got %b want 00001", f); else n_pass++;
        run_one(1'b0, 8'h7F, 27'h400000C, 5'b0, 1'b1, 1'b0, r, f, m, lat);
        n_total++; if (r !== 32'h3F800001) $display("FAIL tie_odd_rtz got %h want 3f800001", r); else n_pass++;
        n_total++; if (f !== NX) $display("FAIL tie_odd_rtz_flags got %b want 00001", f); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] r; logic [4:0] f; logic m; int lat;
        run_one(1'b0, 8'hFE, 27'h7FFFFFC, 5'b0, 1'b0, 1'b0, r, f, m, lat);
        n_total++; if (r !== 32'h7F800000) $display("FAIL ovf_rne got %h want 7f800000", r); else n_pass++;
        n_total++; if (f !== (OF | NX)) $display("FAIL ovf_rne_flags got %b want 00101", f); else n_pass++;
        run_one(1'b0, 8'hFE, 27'h7FFFFFC, 5'b0, 1'b1, 1'b0, r, f, m, lat);
        n_total++; if (r !== 32'h7F7FFFFF) $display("FAIL ovf_rtz got %h want 7f7fffff", r); else n_pass++;
        n_total++; if (f !== NX) $display("FAIL ovf_rtz_flags got %b want 00001", f); else n_pass++;
        run_one(1'b1, 8'hFE, 27'h7FFFFFC, 5'b0, 1'b0, 1'b0, r, f, m, lat);
        n_total++; if (r !== 32'hFF800000) $display("FAIL ovf_neg got %h want ff800000", r); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc = 0; int out_n = 0; int first = -1; int last = -1; logic rdy; logic vo;
        logic [31:0] r; logic [31:0] got [4]; int extra = 0;
        @(negedge clk);
        bus.ready_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (acc < 4) drive(1'b0, 8'h7F, 27'h4000000 + 27'(acc << 3), 5'b0, 1'b0, 1'b0);
            else bus.valid_in = 1'b0;
            #1 rdy = bus.ready_out;
            @(posedge clk);
            if (rdy && acc < 4) acc++;
        end
        @(negedge clk);
        n_total++; if (acc !== 2) $display("FAIL stall_accepted got %0d want 2", acc); else n_pass++;
        n_total++; if (bus.ready_out !== 1'b0) $display("FAIL stall_ready got %b want 0", bus.ready_out); else n_pass++;
        n_total++; if (bus.valid_out !== 1'b1) $display("FAIL stall_valid got %b want 1", bus.valid_out); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.result !== 32'h3F800000) $display("FAIL stall_hold got %h want 3f800000", bus.result); else n_pass++;
        for (int c = 0; c < 20 && out_n < 4; c++) begin
            @(negedge clk);
            bus.ready_in = 1'b1;
            if (acc < 4) drive(1'b0, 8'h7F, 27'h4000000 + 27'(acc << 3), 5'b0, 1'b0, 1'b0);
            else bus.valid_in = 1'b0;
            #1 rdy = bus.ready_out; vo = bus.valid_out; r = bus.result;
            @(posedge clk);
            if (rdy && acc < 4) acc++;
            if (vo) begin
                got[out_n] = r;
                if (out_n == 0) first = c;
                last = c;
                out_n++;
            end
        end
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.valid_out !== 1'b0) extra++;
        end
        n_total++; if (out_n !== 4) $display("FAIL drain_count got %0d want 4", out_n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (got[i] !== 32'h3F800000 + 32'(i)) $display("FAIL drain_order[%0d] got %h want %h", i, got[i], 32'h3F800000 + 32'(i));
            else n_pass++;
        end
        n_total++; if (last - first !== 3) $display("FAIL drain_rate got %0d want 3", last - first); else n_pass++;
        n_total++; if (extra !== 0) $display("FAIL drain_dup got %0d want 0", extra); else n_pass++;
    endtask

    task automatic test_specials_and_reset();
        logic [31:0] r; logic [4:0] f; logic m; int lat; int seen = 0;
        run_one(1'b0, 8'hFF, 27'h6000000, NV, 1'b0, 1'b0, r, f, m, lat);
        n_total++; if (r !== 32'h7FC00000) $display("FAIL nan_result got %h want 7fc00000", r); else n_pass++;
        n_total++; if (f !== NV) $display("FAIL nan_flags got %b want 10000", f); else n_pass++;
        run_one(1'b1, 8'h7F, 27'h0000000, 5'b0, 1'b0, 1'b0, r, f, m, lat);
        n_total++; if (r !== 32'h80000000) $display("FAIL zero_result got %h want 80000000", r); else n_pass++;
        n_total++; if (f !== 5'b0) $display("FAIL zero_flags got %b want 00000", f); else n_pass++;
        @(negedge clk);
        bus.ready_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b0, 8'h7F, 27'h4000000, 5'b0, 1'b0, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (bus.valid_out !== 1'b0) $display("FAIL rst_flight_valid got %b want 0", bus.valid_out); else n_pass++;
        rst_n = 1'b1;
        bus.ready_in = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.valid_out !== 1'b0) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL rst_flight_emit got %0d want 0", seen); else n_pass++;
        n_total++; if (bus.ready_out !== 1'b1) $display("FAIL rst_flight_ready got %b want 1", bus.ready_out); else n_pass++;
    endtask

    task automatic test_subnormal();
        logic [31:0] r; logic [4:0] f; logic m; int lat;
        logic [31:0] exp_r; logic [4:0] exp_f;
`ifdef FP_PACK_SUBNORM_EN
        exp_r = 32'h00000002; exp_f = 5'b0;
`else
        exp_r = 32'h00000000; exp_f = UF | NX;
`endif
        run_one(1'b0, 8'h00, 27'h0000010, 5'b0, 1'b0, 1'b0, r, f, m, lat);
        n_total++; if (r !== exp_r) $display("FAIL subnorm_result got %h want %h", r, exp_r); else n_pass++;
        n_total++; if (f !== exp_f) $display("FAIL subnorm_flags got %b want %b", f, exp_f); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_overflow();
        test_back_to_back();
        test_specials_and_reset();
        test_subnormal();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
